pipelined_mux_tree: RTL and testbench

//   Parametrised N:1 mux of WIDTH-bit words built as a log2(N)-level tree of 2:1 stages.

---
 rtl/pmux_pkg.sv | 18 +
 rtl/mux2_stage.sv | 50 +++++
 rtl/pipelined_mux_tree.sv | 85 ++++++++
 tb/tb_pipelined_mux_tree.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pmux_pkg.sv
// Shared definitions for the pipelined mux tree.
//   clog2     : ceiling log2, used to derive the tree depth / select width
//   MODE_EXT  : select comes from the S port
//   MODE_SCAN : select comes from the internal round-robin counter
package pmux_pkg;

    localparam logic MODE_EXT  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/mux2_stage.sv
// One registered level of the mux tree: WORDS words in, WORDS/2 words out.
// Output word j = sin[SEL_BIT] ? din word 2j+1 : din word 2j.
// The valid bit always advances on CE; the data and select registers only
// load when the incoming sample is valid, so the last valid result is held
// across bubbles.
// Ports:
//   CLK, ASYNCRESETN, CE : clock, async active-low reset, clock enable
//   din  / vin / sin     : incoming words, valid, full select value
//   dout / vout / sout   : registered words, valid, select value
module mux2_stage #(
    parameter int WORDS   = 4,
    parameter int WIDTH   = 1,
    parameter int SELW    = 2,
    parameter int SEL_BIT = 0
) (
    input  logic                         CLK,
    input  logic                         ASYNCRESETN,
    input  logic                         CE,
    input  logic [WORDS*WIDTH-1:0]       din,
    input  logic                         vin,
    input  logic [SELW-1:0]              sin,
    output logic [(WORDS/2)*WIDTH-1:0]   dout,
    output logic                         vout,
    output logic [SELW-1:0]              sout
);

    logic [(WORDS/2)*WIDTH-1:0] mux;

    always_comb begin
        mux = '0;
        for (int j = 0; j < WORDS / 2; j++)
            mux[j*WIDTH +: WIDTH] = sin[SEL_BIT] ? din[(2*j+1)*WIDTH +: WIDTH]
                                                 : din[(2*j)*WIDTH +: WIDTH];
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            dout <= '0;
            vout <= 1'b0;
            sout <= '0;
        end else if (CE) begin
            vout <= vin;
            if (vin) begin
                dout <= mux;
                sout <= sin;
            end
        end
    end

endmodule

// File: rtl/pipelined_mux_tree.sv
// N:1 mux of WIDTH-bit words, built as L = clog2(N) registered 2:1 levels.
// Stage k resolves select bit k (LSB first). Latency is L cycles from the
// sample being presented to O/SEL_O/VALID_O.
// Ports:
//   CLK, ASYNCRESETN, CE : clock, async active-low reset, whole-block enable
//   MODE                 : 0 = select from S, 1 = internal scan counter
//   I                    : N words, word k at I[k*WIDTH +: WIDTH]
//   S                    : external select
//   VALID_IN             : I/S sample valid this cycle
//   O, SEL_O, VALID_O    : selected word, select that produced it, valid pulse
module pipelined_mux_tree
    import pmux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 1,
    localparam int L     = clog2(N)
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    input  logic                 CE,
    input  logic                 MODE,
    input  logic [N*WIDTH-1:0]   I,
    input  logic [L-1:0]         S,
    input  logic                 VALID_IN,
    output logic [WIDTH-1:0]     O,
    output logic [L-1:0]         SEL_O,
    output logic                 VALID_O
);

    logic [L-1:0] cnt;
    logic [L-1:0] sel;

    // All tree levels packed back to back: level 0 is I (N words), level k
    // starts at word 2N - 2N/2^k; the final single word sits at 2N-2.
    logic [(2*N-1)*WIDTH-1:0] tree;
    logic [L:0]               vld_pipe;
    logic [L:0][L-1:0]        sel_pipe;

    assign sel = (MODE == MODE_SCAN) ? cnt : S;

    // Counter value is consumed by the current sample, then advances.
    // N is a power of two, so natural L-bit overflow gives the wrap.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN)
            cnt <= '0;
        else if (CE) begin
            if (MODE == MODE_EXT)
                cnt <= '0;
            else if (VALID_IN)
                cnt <= cnt + 1'b1;
        end
    end

    assign tree[N*WIDTH-1:0] = I;
    assign vld_pipe[0]       = VALID_IN;
    assign sel_pipe[0]       = sel;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int WORDS = N >> k;
        localparam int IOFF  = 2*N - ((2*N) >> k);
        localparam int OOFF  = 2*N - ((2*N) >> (k+1));

        mux2_stage #(
            .WORDS   (WORDS),
            .WIDTH   (WIDTH),
            .SELW    (L),
            .SEL_BIT (k)
        ) u_stage (
            .CLK         (CLK),
            .ASYNCRESETN (ASYNCRESETN),
            .CE          (CE),
            .din         (tree[IOFF*WIDTH +: WORDS*WIDTH]),
            .vin         (vld_pipe[k]),
            .sin         (sel_pipe[k]),
            .dout        (tree[OOFF*WIDTH +: (WORDS/2)*WIDTH]),
            .vout        (vld_pipe[k+1]),
            .sout        (sel_pipe[k+1])
        );
    end

    assign O       = tree[(2*N-2)*WIDTH +: WIDTH];
    assign SEL_O   = sel_pipe[L];
    assign VALID_O = vld_pipe[L];

endmodule

// File: tb/tb_pipelined_mux_tree.sv
module tb_pipelined_mux_tree;

    localparam int N = 4;
    localparam int W = 8;
    localparam int L = 2;
    localparam logic [N*W-1:0] IDEF = 32'hD4C3B2A1;

    logic           CLK = 1'b0;
    logic           ASYNCRESETN = 1'b0;
    logic           CE = 1'b0;
    logic           MODE = 1'b0;
    logic [N*W-1:0] I;
    logic [L-1:0]   S;
    logic           VALID_IN = 1'b0;
    logic [W-1:0]   O;
    logic [L-1:0]   SEL_O;
    logic           VALID_O;

    pipelined_mux_tree #(.N(N), .WIDTH(W)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .CE          (CE),
        .MODE        (MODE),
        .I           (I),
        .S           (S),
        .VALID_IN    (VALID_IN),
        .O           (O),
        .SEL_O       (SEL_O),
        .VALID_O     (VALID_O)
    );

    always #5 CLK = ~CLK;

    // Reference model: history of every CE-qualified sample since reset.
    // The output after a CE edge is the entry presented L-1 CE edges earlier;
    // O/SEL_O show the newest valid entry at or before that point.
    typedef struct {
        bit           v;
        logic [W-1:0] d;
        logic [L-1:0] s;
    } smp_t;

    smp_t        hist[$];
    int unsigned cnt_m;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] got[$];

    typedef struct {
        bit           vin;
        logic [L-1:0] s;
        logic [N*W-1:0] i;
        logic [W-1:0] eo;
        logic [L-1:0] es;
        bit           ev;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_exp(output logic [W-1:0] eo, output logic [L-1:0] es,
                                      output bit ev);
        int idx;
        idx = hist.size() - L;
        eo = '0; es = '0; ev = 1'b0;
        if (idx >= 0) ev = hist[idx].v;
        for (int j = 0; j <= idx; j++)
            if (hist[j].v) begin
                eo = hist[j].d;
                es = hist[j].s;
            end
    endfunction

    task automatic step(bit ce, bit mode, bit vin, logic [L-1:0] s, bit mchk);
        logic [L-1:0] sel;
        smp_t         e;
        logic [W-1:0] eo;
        logic [L-1:0] es;
        bit           ev;
        CE = ce; MODE = mode; VALID_IN = vin; S = s;
        @(posedge CLK);
        if (ce) begin
            sel = mode ? L'(cnt_m) : s;
            e.v = vin;
            e.d = W'(I >> (W * sel));
            e.s = sel;
            hist.push_back(e);
            if (!mode)    cnt_m = 0;
            else if (vin) cnt_m = (cnt_m + 1) % N;
        end
        #1;
        if (ce && VALID_O) got.push_back({6'd0, SEL_O, O});
        if (mchk) begin
            model_exp(eo, es, ev);
            chk("model_o",   32'(O),       32'(eo));
            chk("model_sel", 32'(SEL_O),   32'(es));
            chk("model_vld", 32'(VALID_O), 32'(ev));
        end
    endtask

    // Assert reset between edges (caller is just after an edge), check the
    // outputs clear before the next edge, then release just after it.
    task automatic rst_mid();
        #3 ASYNCRESETN = 1'b0;
        #1;
        chk("rst_o",   32'(O),       32'd0);
        chk("rst_sel", 32'(SEL_O),   32'd0);
        chk("rst_vld", 32'(VALID_O), 32'd0);
        hist.delete();
        cnt_m = 0;
        @(posedge CLK);
        #1 ASYNCRESETN = 1'b1;
    endtask

    task automatic chk_got(string name, logic [15:0] exp[$]);
        chk({name, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size(); k++)
            if (k < got.size())
                chk($sformatf("%s_%0d", name, k), 32'(got[k]), 32'(exp[k]));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd2, IDEF,         8'h00, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, IDEF,         8'hC3, 2'd2, 1'b1};
        tbl[2]  = '{1'b0, 2'd0, IDEF,         8'hC3, 2'd2, 1'b0};
        tbl[3]  = '{1'b1, 2'd0, IDEF,         8'hC3, 2'd2, 1'b0};
        tbl[4]  = '{1'b1, 2'd1, IDEF,         8'hA1, 2'd0, 1'b1};
        tbl[5]  = '{1'b1, 2'd2, IDEF,         8'hB2, 2'd1, 1'b1};
        tbl[6]  = '{1'b1, 2'd3, IDEF,         8'hC3, 2'd2, 1'b1};
        tbl[7]  = '{1'b0, 2'd0, 32'hFFFFFFFF, 8'hD4, 2'd3, 1'b1};
        tbl[8]  = '{1'b0, 2'd0, 32'hFFFFFFFF, 8'hD4, 2'd3, 1'b0};
        tbl[9]  = '{1'b1, 2'd1, IDEF,         8'hD4, 2'd3, 1'b0};
        tbl[10] = '{1'b0, 2'd3, IDEF,         8'hB2, 2'd1, 1'b1};
        tbl[11] = '{1'b1, 2'd3, IDEF,         8'hB2, 2'd1, 1'b0};
        tbl[12] = '{1'b0, 2'd0, IDEF,         8'hD4, 2'd3, 1'b1};
        tbl[13] = '{1'b0, 2'd0, IDEF,         8'hD4, 2'd3, 1'b0};

        I = IDEF; S = '0;
        hist.delete(); cnt_m = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("init_o",   32'(O),       32'd0);
        chk("init_sel", 32'(SEL_O),   32'd0);
        chk("init_vld", 32'(VALID_O), 32'd0);
        ASYNCRESETN = 1'b1;

        // Static select, back-to-back, input change after capture, bubbles.
        for (int r = 0; r < 14; r++) begin
            I = tbl[r].i;
            step(1'b1, 1'b0, tbl[r].vin, tbl[r].s, 1'b0);
            chk($sformatf("tbl%0d_o", r),   32'(O),       32'(tbl[r].eo));
            chk($sformatf("tbl%0d_sel", r), 32'(SEL_O),   32'(tbl[r].es));
            chk($sformatf("tbl%0d_vld", r), 32'(VALID_O), 32'(tbl[r].ev));
        end
        I = IDEF;

        // Reset with samples in flight: nothing emerges after release.
        step(1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
        rst_mid();
        got.delete();
        repeat (3) step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        chk_got("flush", '{});

        // Scan with wrap.
        got.delete();
        repeat (6) step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
        repeat (2) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        chk_got("scan", '{16'h00A1, 16'h01B2, 16'h02C3, 16'h03D4, 16'h00A1, 16'h01B2});

        // Mode drop and return restarts the counter.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        got.delete();
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
        repeat (2) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        chk_got("rescan", '{16'h00A1});

        // Stall with external select: no loss, no repeat.
        got.delete();
        step(1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
        step(1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
        step(1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        chk_got("stall", '{16'h00A1, 16'h01B2, 16'h02C3, 16'h03D4});

        // Stall in scan mode: counter frozen while CE=0.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        got.delete();
        repeat (2) step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
        repeat (2) step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
        repeat (2) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        chk_got("scan_stall", '{16'h00A1, 16'h01B2, 16'h02C3, 16'h03D4});

        // Reset mid-scan: counter restarts at 0, in-flight sample dropped.
        repeat (2) step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
        rst_mid();
        got.delete();
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
        repeat (2) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        chk_got("rst_scan", '{16'h00A1});

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            I = $urandom;
            if ($urandom_range(0, 63) == 0) rst_mid();
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
